// File: rtl/mac16_acc.sv
// mac16_acc: registered 16x16 multiply-accumulate over in_last-terminated frames.
module array16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 16; i++) p = p + ((b[i] ? {16'b0, a} : 32'b0) << i);
  end
endmodule

module mac16_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);
  typedef enum logic {IDLE, FULL} state_t;
  state_t state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic last_q, last_d, v1_q, v1_d;
  logic [ACC_W-1:0] acc_q, acc_d, oacc_q, oacc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_n;
  logic ovf_q, ovf_d, oovf_q, oovf_d, ovf_n;
  logic stall, accept;
  logic [31:0] p;
  logic [ACC_W:0] sum;
  array16 u_mul (.a(a_q), .b(b_q), .p(p));
  assign out_valid = state_q == FULL;
  assign out_acc   = oacc_q;
  assign out_cnt   = ocnt_q;
  assign out_ovf   = oovf_q;
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~rst & ~stall;
    accept   = in_valid & in_ready;
    sum      = {1'b0, acc_q} + (ACC_W+1)'(p);
    ovf_n    = ovf_q | sum[ACC_W];
    cnt_n    = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    last_d   = last_q;
    v1_d     = v1_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    oacc_d   = oacc_q;
    ocnt_d   = ocnt_q;
    oovf_d   = oovf_q;
    if (!stall) begin
      v1_d    = accept;
      a_d     = accept ? a : a_q;
      b_d     = accept ? b : b_q;
      last_d  = accept ? in_last : last_q;
      state_d = IDLE;
      if (v1_q && last_q) begin
        oacc_d  = sum[ACC_W-1:0];
        ocnt_d  = cnt_n;
        oovf_d  = ovf_n;
        state_d = FULL;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else if (v1_q) begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_n;
        ovf_d = ovf_n;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      v1_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      oacc_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      v1_q    <= v1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      oacc_q  <= oacc_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
endmodule
